// File: rtl/serial_subtractor.sv
// Bit-serial A-B-BIN, LSB first, one borrow FF; signed overflow flag under SERIAL_SUB_OVF_EN.
// Latency: WIDTH SHIFT cycles after accept, then DONE until taken.
// Backpressure: result held in DONE while out_ready=0; no new operands accepted until handoff.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_q;
  logic [CW-1:0]    cnt;
  logic             borrow, bout_q;
  logic             x, y, d, borrow_nxt, last_step, accept, handoff;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

  always_comb begin
    x          = a_sr[0];
    y          = b_sr[0];
    d          = x ^ y ^ borrow;
    borrow_nxt = (~x & y) | (~(x ^ y) & borrow);
    last_step  = (cnt == CW'(WIDTH - 1));
    accept     = in_valid && in_ready;
    handoff    = out_valid && out_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (handoff) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // a_sr doubles as the result shift register: each step consumes a_sr[0]
  // and inserts the new difference bit at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= {d, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          borrow <= borrow_nxt;
          cnt    <= last_step ? '0 : cnt + 1'b1;
          if (last_step) begin
            diff_q <= {d, a_sr[WIDTH-1:1]};
            bout_q <= borrow_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb, ovf_q;

  // On the last step d is the result sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if ((state == SHIFT) && last_step) begin
      ovf_q <= (a_msb != b_msb) && (d != a_msb);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model, per-cycle compare, directed and random ops.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, bout, ovf;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, bout, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
    int   du, ds, sa, sb;
    logic ov;
    du = int'(aa) - int'(bb) - int'(bi);
    sa = aa[W-1] ? int'(aa) - (1 << W) : int'(aa);
    sb = bb[W-1] ? int'(bb) - (1 << W) : int'(bb);
    ds = sa - sb - int'(bi);
    ov = (ds < -(1 << (W-1))) || (ds > (1 << (W-1)) - 1);
`ifndef SERIAL_SUB_OVF_EN
    ov = 1'b0;
`endif
    return {ov, (du < 0), du[W-1:0]};
  endfunction

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res = '0;
  logic         busy = 1'b0;
  logic         ho_seen = 1'b0;
  logic         iv_at_ho = 1'b0;
  logic         b2b_mode = 1'b0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           last_ho = 0;

  // Compare process: outputs are checked at negedge; then the upcoming edge's handshakes are predicted.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      busy     = 1'b0;
      ho_seen  = 1'b0;
      last_res = '0;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_bout", bout, 0);
      check("rst_ovf", ovf, 0);
    end else begin
      cyc++;
      check("in_ready", in_ready, !busy);
      check("out_valid", out_valid, busy && (cyc >= acc_cyc + W + 1));
      if (out_valid) begin
        check("out_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          check("diff", diff, exp_q[0][W-1:0]);
          check("bout", bout, exp_q[0][W]);
          check("ovf", ovf, exp_q[0][W+1]);
        end
      end else begin
        check("diff_retained", diff, last_res[W-1:0]);
        check("bout_retained", bout, last_res[W]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) last_res = exp_q.pop_front();
        busy     = 1'b0;
        last_ho  = cyc;
        ho_seen  = 1'b1;
        iv_at_ho = in_valid;
      end else if (in_valid && !busy) begin
        exp_q.push_back(model(a, b, bin));
        busy    = 1'b1;
        acc_cyc = cyc;
        if (b2b_mode && ho_seen && iv_at_ho) check("b2b_gap", cyc - last_ho, 1);
      end
    end
  end

  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
    int n = 0;
    a = aa; b = bb; bin = bi; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                    input logic [W-1:0] ed, input logic eb, input logic eo);
    int   n = 0;
    logic oe = eo;
`ifndef SERIAL_SUB_OVF_EN
    oe = 1'b0;
`endif
    check("pin_model", model(aa, bb, bi), {oe, eb, ed});
    send(aa, bb, bi);
    in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("op_timeout", out_valid, 1);
    check("lit_diff", diff, ed);
    check("lit_bout", bout, eb);
    check("lit_ovf", ovf, oe);
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    op(8'hFF, 8'h7F, 1'b1, 8'h7F, 1'b0, 1'b1);

    // Backpressure: hold result 5 cycles, with stray in_valid pulses in SHIFT and DONE.
    out_ready = 1'b0;
    send(8'h33, 8'h11, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1; a = 8'hAA; b = 8'h01; bin = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("hold_timeout", out_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'(i * 17); b = 8'h02;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_diff", diff, 8'h22);
      check("hold_bout", bout, 0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // Reset in the fourth SHIFT cycle aborts the operation.
    send(8'h44, 8'h22, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 check("release_in_ready", in_ready, 1);
    op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Back-to-back random stream, in_valid held high throughout.
    b2b_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
    end
    in_valid = 1'b0;
    wait_idle();
    b2b_mode = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
